vixen_l1i_cache: RTL and testbench

Blocking, direct-mapped L1 instruction cache that answers the frontend fetch port (`l1i_addr` in, `l1i_data`/`l1i_hit` out, one-cycle registered response). A line miss triggers refill from L2 over a valid/ready request channel plus a 4-beat, 128-bit response channel. While the refill is outstanding, all lookups report miss, and the frontend re-fetches.

---
 rtl/vixen_l1i_cache.sv | 172 +++++++++++++++++
 tb/tb_vixen_l1i_cache.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vixen_l1i_cache.sv
// Blocking direct-mapped L1 instruction cache with one-cycle registered lookup
// and a 4-beat L2 refill engine.
module vixen_l1i_cache #(
    parameter int unsigned NUM_SETS  = 64,
    parameter int unsigned LINE_BITS = 512
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   l1i_req,
    input  logic [63:0]            l1i_addr,
    output logic [LINE_BITS-1:0]   l1i_data,
    output logic                   l1i_hit,
    input  logic                   flush,
    output logic                   l2_req_valid,
    input  logic                   l2_req_ready,
    output logic [63:0]            l2_req_addr,
    input  logic                   l2_rsp_valid,
    input  logic [LINE_BITS/4-1:0] l2_rsp_data,
    output logic                   miss_busy,
    output logic [31:0]            perf_hits,
    output logic [31:0]            perf_misses
);

    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned OFF_W  = 6;
    localparam int unsigned TAG_W  = 64 - OFF_W - IDX_W;
    localparam int unsigned BEAT_W = LINE_BITS / 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL
    } state_e;

    state_e                state_q, state_d;
    logic [63:0]           miss_addr_q, miss_addr_d;
    logic [1:0]            beat_cnt_q, beat_cnt_d;
    logic                  kill_q, kill_d;
    logic [NUM_SETS-1:0]   valid_q, valid_d;
    logic [31:0]           perf_hits_q, perf_hits_d;
    logic [31:0]           perf_misses_q, perf_misses_d;
    logic                  hit_q;
    logic [LINE_BITS-1:0]  rdata_q;
    logic                  req_valid_q;
    logic                  busy_q;

    logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
    logic [LINE_BITS-1:0]  data_mem [NUM_SETS];
    logic [BEAT_W-1:0]     fill_buf [3];

    logic [IDX_W-1:0]      idx_c;
    logic [TAG_W-1:0]      tag_c;
    logic [IDX_W-1:0]      miss_idx_c;
    logic [TAG_W-1:0]      miss_tag_c;
    logic                  hit_c;
    logic                  install_c;
    logic                  buf_we_c;
    logic                  unused_c;

    assign idx_c      = l1i_addr[OFF_W +: IDX_W];
    assign tag_c      = l1i_addr[63 -: TAG_W];
    assign miss_idx_c = miss_addr_q[OFF_W +: IDX_W];
    assign miss_tag_c = miss_addr_q[63 -: TAG_W];
    assign unused_c   = ^l1i_addr[OFF_W-1:0];

    // Lookups are only served while no refill is outstanding.
    assign hit_c = l1i_req & (state_q == ST_IDLE) & ~flush & valid_q[idx_c]
                 & (tag_mem[idx_c] == tag_c);

    // Refill FSM next-state and control.
    always_comb begin
        state_d       = state_q;
        miss_addr_d   = miss_addr_q;
        beat_cnt_d    = beat_cnt_q;
        kill_d        = kill_q;
        perf_misses_d = perf_misses_q;
        install_c     = 1'b0;
        buf_we_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (l1i_req && !flush && !hit_c) begin
                    state_d       = ST_REQ;
                    miss_addr_d   = {l1i_addr[63:OFF_W], OFF_W'(0)};
                    perf_misses_d = perf_misses_q + 32'd1;
                end
            end
            ST_REQ: begin
                if (l2_req_ready) begin
                    state_d    = ST_FILL;
                    beat_cnt_d = 2'd0;
                end
            end
            ST_FILL: begin
                if (l2_rsp_valid) begin
                    if (beat_cnt_q == 2'd3) begin
                        install_c = ~kill_q & ~flush;
                        state_d   = ST_IDLE;
                        kill_d    = 1'b0;
                    end else begin
                        buf_we_c   = 1'b1;
                        beat_cnt_d = beat_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A flush during a refill that is not finishing this cycle poisons it.
        if (flush && (state_q != ST_IDLE) && (state_d != ST_IDLE)) begin
            kill_d = 1'b1;
        end

        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end
        if (install_c) begin
            valid_d[miss_idx_c] = 1'b1;
        end

        perf_hits_d = perf_hits_q + 32'(hit_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            miss_addr_q   <= '0;
            beat_cnt_q    <= 2'd0;
            kill_q        <= 1'b0;
            valid_q       <= '0;
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
            hit_q         <= 1'b0;
            rdata_q       <= '0;
            req_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            miss_addr_q   <= miss_addr_d;
            beat_cnt_q    <= beat_cnt_d;
            kill_q        <= kill_d;
            valid_q       <= valid_d;
            perf_hits_q   <= perf_hits_d;
            perf_misses_q <= perf_misses_d;
            hit_q         <= hit_c;
            rdata_q       <= data_mem[idx_c];
            req_valid_q   <= (state_d == ST_REQ);
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    // Storage arrays and the beat buffer carry no reset; validity lives in valid_q.
    always_ff @(posedge clk) begin
        if (buf_we_c) begin
            fill_buf[beat_cnt_q] <= l2_rsp_data;
        end
        if (install_c) begin
            data_mem[miss_idx_c] <= {l2_rsp_data, fill_buf[2], fill_buf[1], fill_buf[0]};
            tag_mem[miss_idx_c]  <= miss_tag_c;
        end
    end

    assign l1i_hit      = hit_q;
    assign l1i_data     = rdata_q;
    assign l2_req_valid = req_valid_q;
    assign l2_req_addr  = miss_addr_q;
    assign miss_busy    = busy_q;
    assign perf_hits    = perf_hits_q;
    assign perf_misses  = perf_misses_q;

endmodule

// File: tb/tb_vixen_l1i_cache.sv
// Self-checking bench for vixen_l1i_cache: directed table, corner sequences and
// randomized traffic against a transaction-level cache model.
module tb_vixen_l1i_cache;

    logic         clk;
    logic         rst_n;
    logic         l1i_req;
    logic [63:0]  l1i_addr;
    logic [511:0] l1i_data;
    logic         l1i_hit;
    logic         flush;
    logic         l2_req_valid;
    logic         l2_req_ready;
    logic [63:0]  l2_req_addr;
    logic         l2_rsp_valid;
    logic [127:0] l2_rsp_data;
    logic         miss_busy;
    logic [31:0]  perf_hits;
    logic [31:0]  perf_misses;

    vixen_l1i_cache #(.NUM_SETS(64), .LINE_BITS(512)) dut (
        .clk(clk), .rst_n(rst_n),
        .l1i_req(l1i_req), .l1i_addr(l1i_addr), .l1i_data(l1i_data), .l1i_hit(l1i_hit),
        .flush(flush),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_addr(l2_req_addr),
        .l2_rsp_valid(l2_rsp_valid), .l2_rsp_data(l2_rsp_data),
        .miss_busy(miss_busy), .perf_hits(perf_hits), .perf_misses(perf_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: refill phase 0=none, 1=requesting, 2=receiving beats.
    int           phase;
    int           beats;
    logic         kill;
    logic [63:0]  miss_addr;
    logic [127:0] fbuf [4];
    bit           m_valid [64];
    logic [51:0]  m_tag [64];
    logic [511:0] m_data [64];
    logic [31:0]  m_hits;
    logic [31:0]  m_misses;

    typedef struct {
        logic        req;
        logic [63:0] addr;
        logic        rdy;
        logic        rv;
        logic        e_hit;
        logic        e_reqv;
        logic        e_busy;
        logic [31:0] e_hits;
        logic [31:0] e_misses;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [127:0] beat_of(input logic [63:0] la, input int k);
        if (la == 64'h1040) return {{31{4'hA}}, 4'(k)};
        return {la, 32'hBEEF0000 + 32'(k), la[31:0] ^ 32'h5A5A5A5A};
    endfunction

    task automatic model_reset();
        phase = 0; beats = 0; kill = 1'b0; miss_addr = '0;
        m_hits = '0; m_misses = '0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_hit", 512'(l1i_hit), 512'(0));
        chk("rst_data", l1i_data, 512'(0));
        chk("rst_reqv", 512'(l2_req_valid), 512'(0));
        chk("rst_addr", 512'(l2_req_addr), 512'(0));
        chk("rst_busy", 512'(miss_busy), 512'(0));
        chk("rst_phits", 512'(perf_hits), 512'(0));
        chk("rst_pmiss", 512'(perf_misses), 512'(0));
    endtask

    // One clock cycle: drive inputs, advance the model, check outputs after the edge.
    task automatic cyc(input logic req, input logic [63:0] addr, input logic fl,
                       input logic rdy, input logic rv);
        int           idx;
        int           pn;
        int           mi;
        logic         hit;
        logic         nkill;
        logic [511:0] exp_d;
        logic [127:0] bd;
        idx   = int'(addr[11:6]);
        hit   = req && (phase == 0) && !fl && m_valid[idx] && (m_tag[idx] == addr[63:12]);
        exp_d = m_data[idx];
        bd    = (phase == 2) ? beat_of(miss_addr, beats) : {$urandom, $urandom, $urandom, $urandom};
        l1i_req = req; l1i_addr = addr; flush = fl;
        l2_req_ready = rdy; l2_rsp_valid = rv; l2_rsp_data = bd;

        pn    = phase;
        nkill = kill | (fl && phase != 0);
        if (hit) m_hits++;
        if (req && phase == 0 && !fl && !hit) begin
            pn = 1; miss_addr = {addr[63:6], 6'b0}; m_misses++;
        end
        if (phase == 1 && rdy) begin
            pn = 2; beats = 0;
        end
        if (fl) for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        if (phase == 2 && rv) begin
            fbuf[beats] = bd;
            if (beats == 3) begin
                if (!kill && !fl) begin
                    mi = int'(miss_addr[11:6]);
                    m_valid[mi] = 1'b1;
                    m_tag[mi]   = miss_addr[63:12];
                    m_data[mi]  = {fbuf[3], fbuf[2], fbuf[1], fbuf[0]};
                end
                pn = 0; nkill = 1'b0;
            end else begin
                beats++;
            end
        end
        phase = pn; kill = nkill;

        @(posedge clk); #1;
        chk("hit", 512'(l1i_hit), 512'(hit));
        if (hit) chk("data", l1i_data, exp_d);
        chk("reqv", 512'(l2_req_valid), 512'(phase == 1));
        if (phase == 1) chk("req_addr", 512'(l2_req_addr), 512'(miss_addr));
        chk("busy", 512'(miss_busy), 512'(phase != 0));
        chk("perf_hits", 512'(perf_hits), 512'(m_hits));
        chk("perf_misses", 512'(perf_misses), 512'(m_misses));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && phase != 0; i++) cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        chk("drain_idle", 512'(phase), 512'(0));
    endtask

    // Miss at addr, hold ready low for stall cycles, then deliver beats per pattern.
    task automatic do_fill(input logic [63:0] addr, input int stall, input logic [5:0] pat);
        cyc(1'b1, addr, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < stall; i++) cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20 && phase != 0; i++)
            cyc(1'b0, 64'h0, 1'b0, 1'b0, (i < 6) ? pat[i] : 1'b1);
        chk("fill_done", 512'(phase), 512'(0));
    endtask

    initial begin
        logic [511:0] d;
        logic [127:0] b0_exp, b3_exp;
        logic [51:0]  tags [4];
        logic [63:0]  a;

        tbl[0] = '{1'b1, 64'h1040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd1};
        tbl[1] = '{1'b0, 64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd1};
        tbl[2] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd1};
        tbl[3] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd1};
        tbl[4] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd1};
        tbl[5] = '{1'b1, 64'h1070, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1};
        tbl[6] = '{1'b1, 64'h1070, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1};
        tbl[7] = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1};

        rst_n = 1'b0; l1i_req = 1'b0; l1i_addr = '0; flush = 1'b0;
        l2_req_ready = 1'b0; l2_rsp_valid = 1'b0; l2_rsp_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;

        // Cold miss at 0x1040, then retry hit at 0x1070.
        b0_exp = {{31{4'hA}}, 4'h0};
        b3_exp = {{31{4'hA}}, 4'h3};
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].req, tbl[i].addr, 1'b0, tbl[i].rdy, tbl[i].rv);
            chk($sformatf("t%0d_hit", i), 512'(l1i_hit), 512'(tbl[i].e_hit));
            chk($sformatf("t%0d_reqv", i), 512'(l2_req_valid), 512'(tbl[i].e_reqv));
            if (tbl[i].e_reqv) chk($sformatf("t%0d_addr", i), 512'(l2_req_addr), 512'(64'h1040));
            chk($sformatf("t%0d_busy", i), 512'(miss_busy), 512'(tbl[i].e_busy));
            chk($sformatf("t%0d_phits", i), 512'(perf_hits), 512'(tbl[i].e_hits));
            chk($sformatf("t%0d_pmiss", i), 512'(perf_misses), 512'(tbl[i].e_misses));
            if (i == 6) begin
                d = l1i_data;
                chk("cold_beat0", 512'(d[127:0]), 512'(b0_exp));
                chk("cold_beat3", 512'(d[511:384]), 512'(b3_exp));
            end
        end

        // Ready stall, then gapped beats; both lines must hit afterwards.
        do_fill(64'h2080, 5, 6'b111111);
        cyc(1'b1, 64'h2088, 1'b0, 1'b0, 1'b0);
        chk("stall_hit", 512'(l1i_hit), 512'(1));
        do_fill(64'h30C0, 0, 6'b110101);
        cyc(1'b1, 64'h30C4, 1'b0, 1'b0, 1'b0);
        chk("gap_hit", 512'(l1i_hit), 512'(1));

        // Conflict on index 0.
        do_fill(64'h0000, 0, 6'b111111);
        do_fill(64'h1000, 0, 6'b111111);
        cyc(1'b1, 64'h1000, 1'b0, 1'b0, 1'b0);
        chk("conf_new_hit", 512'(l1i_hit), 512'(1));
        cyc(1'b1, 64'h0000, 1'b0, 1'b0, 1'b0);
        chk("conf_old_miss", 512'(l1i_hit), 512'(0));
        chk("conf_old_reqv", 512'(l2_req_valid), 512'(1));
        drain();

        // Flush after beat 1: refill completes but is not installed.
        cyc(1'b1, 64'h5140, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("flush_busy", 512'(miss_busy), 512'(1));
        cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("flush_done", 512'(miss_busy), 512'(0));
        cyc(1'b1, 64'h5140, 1'b0, 1'b0, 1'b0);
        chk("flush_miss", 512'(l1i_hit), 512'(0));
        chk("flush_refetch", 512'(l2_req_valid), 512'(1));
        drain();

        // Flush on the final beat.
        cyc(1'b1, 64'h6180, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 64'h6180, 1'b0, 1'b0, 1'b0);
        chk("lastflush_miss", 512'(l1i_hit), 512'(0));
        drain();

        // Reset during beat 2.
        cyc(1'b1, 64'h7000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        l2_rsp_valid = 1'b1;
        l2_rsp_data  = beat_of(64'h7000, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset();
        model_reset();
        l2_rsp_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 64'h7000, 1'b0, 1'b0, 1'b0);
        chk("rst_after_miss", 512'(l1i_hit), 512'(0));
        chk("rst_after_reqv", 512'(l2_req_valid), 512'(1));
        drain();

        // Randomized traffic over a few tags and indices.
        tags[0] = 52'h0; tags[1] = 52'h1; tags[2] = 52'h2; tags[3] = 52'hF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3000; i++) begin
            a = {tags[$urandom_range(0, 3)],
                 ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3)),
                 6'($urandom)};
            cyc($urandom_range(0, 9) < 7, a, $urandom_range(0, 49) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
